// File: rtl/choose_multi_if.sv
// Controller-side bundle for the keep/discard decision engine.
interface choose_multi_if #(
    parameter int unsigned TARGET  = 15,
    parameter int unsigned NUM_W   = 3,
    parameter int unsigned PLAYERS = 2
);
    localparam int unsigned SCORE_W = $clog2(TARGET + 1);
    localparam int unsigned PW      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

    logic                       pulse_i;
    logic [NUM_W-1:0]           num;
    logic [PW-1:0]              player;
    logic                       choice;
    logic                       confirm;
    logic [1:0]                 result;
    logic                       pulse_o;
    logic                       timed_out;
    logic                       busy;
    logic [PLAYERS*SCORE_W-1:0] scores;

    modport master (
        output pulse_i, num, player, choice, confirm,
        input  result, pulse_o, timed_out, busy, scores
    );

    modport slave (
        input  pulse_i, num, player, choice, confirm,
        output result, pulse_o, timed_out, busy, scores
    );
endinterface

// File: rtl/choose_multi.sv
// Keep/discard decision engine: owns per-player scores and resolves one roll per turn.
module choose_multi #(
    parameter int unsigned TARGET    = 15,
    parameter int unsigned NUM_W     = 3,
    parameter int unsigned FORCE_NUM = 6,
    parameter int unsigned PLAYERS   = 2,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_i,
    choose_multi_if.slave bus
);
    localparam int unsigned SCORE_W = $clog2(TARGET + 1);
    localparam int unsigned PW      = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;
    localparam int unsigned SUM_W   = SCORE_W + NUM_W + 1;
    localparam int unsigned TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TLAST   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] ResContinue = 2'b00;
    localparam logic [1:0] ResLost     = 2'b01;
    localparam logic [1:0] ResWon      = 2'b10;

    typedef enum logic [1:0] {StIdle, StCheck, StChoose, StHold} state_e;

    state_e             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [NUM_W-1:0]   num_q, num_d;
    logic [PW-1:0]      player_q, player_d;
    logic [SCORE_W-1:0] scores_q [PLAYERS];
    logic [SCORE_W-1:0] scores_d [PLAYERS];
    logic [1:0]         result_q, result_d;
    logic               pulse_q, pulse_d;
    logic               timed_out_q, timed_out_d;

    logic               do_keep, do_discard, expire;
    logic               player_valid;
    logic [SUM_W-1:0]   sum;

    // Next-state: turn FSM, score update on completion, clear override last.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        num_d       = num_q;
        player_d    = player_q;
        scores_d    = scores_q;
        result_d    = result_q;
        pulse_d     = 1'b0;
        timed_out_d = timed_out_q;
        do_keep     = 1'b0;
        do_discard  = 1'b0;
        expire      = 1'b0;
        // Out-of-range players complete as a discard without touching any score.
        player_valid = 32'(player_q) < PLAYERS;
        sum          = '0;
        if (player_valid) begin
            sum = SUM_W'(scores_q[player_q]) + SUM_W'(num_q);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.pulse_i) begin
                    num_d    = bus.num;
                    player_d = bus.player;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (num_q == NUM_W'(FORCE_NUM)) begin
                    do_keep = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = '0;
                    state_d = StChoose;
                end
            end
            StChoose: begin
                // A confirm on the expiry cycle beats the timeout.
                if (bus.confirm) begin
                    state_d = StHold;
                end else if (TIMEOUT != 0 && timer_q == TW'(TLAST)) begin
                    do_discard = 1'b1;
                    expire     = 1'b1;
                    state_d    = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StHold: begin
                // Choice is taken on the release cycle, not the press.
                if (!bus.confirm) begin
                    do_keep    = bus.choice;
                    do_discard = !bus.choice;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_keep || do_discard) begin
            pulse_d     = 1'b1;
            timed_out_d = expire;
            result_d    = ResContinue;
            if (do_keep && player_valid) begin
                if (sum > SUM_W'(TARGET)) begin
                    result_d           = ResLost;
                    scores_d[player_q] = '0;
                end else if (sum == SUM_W'(TARGET)) begin
                    result_d           = ResWon;
                    scores_d[player_q] = SCORE_W'(TARGET);
                end else begin
                    scores_d[player_q] = SCORE_W'(sum);
                end
            end
        end

        // New game: drop the turn silently, keep the last reported result.
        if (clear_i) begin
            state_d     = StIdle;
            pulse_d     = 1'b0;
            result_d    = result_q;
            timed_out_d = timed_out_q;
            for (int p = 0; p < int'(PLAYERS); p++) begin
                scores_d[p] = '0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            num_q       <= '0;
            player_q    <= '0;
            result_q    <= ResContinue;
            pulse_q     <= 1'b0;
            timed_out_q <= 1'b0;
            for (int p = 0; p < int'(PLAYERS); p++) begin
                scores_q[p] <= '0;
            end
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            num_q       <= num_d;
            player_q    <= player_d;
            result_q    <= result_d;
            pulse_q     <= pulse_d;
            timed_out_q <= timed_out_d;
            for (int p = 0; p < int'(PLAYERS); p++) begin
                scores_q[p] <= scores_d[p];
            end
        end
    end

    // Flatten the score array onto the output vector.
    always_comb begin
        bus.scores = '0;
        for (int p = 0; p < int'(PLAYERS); p++) begin
            bus.scores[p*SCORE_W +: SCORE_W] = scores_q[p];
        end
    end

    assign bus.result    = result_q;
    assign bus.pulse_o   = pulse_q;
    assign bus.timed_out = timed_out_q;
    assign bus.busy      = (state_q != StIdle);

endmodule

// File: doc/choose_multi.md
# choose_multi

Keep/discard decision engine for the dice game, for multiple players with configurable target, die width, forced-keep value and choice timeout. After each roll the controller pulses the block. The block forces or asks for a keep/discard choice and updates the rolling player's internal score register. It then returns a one-cycle result pulse to the game controller. The block owns the per-player scores, so the controller no longer supplies a score.

## Interface
- TARGET, 15: winning score; SCORE_W = $clog2(TARGET+1)
- NUM_W, 3: width of rolled number
- FORCE_NUM, 6: roll value that is always kept without asking
- PLAYERS, 2: number of players (>=1); PW = max(1,$clog2(PLAYERS))
- TIMEOUT, 1000: cycles allowed in CHOOSE before auto-discard; 0 disables timeout
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous new-game clear of all scores, aborts turn
- pulse_i  in  1  start-of-turn pulse; honoured only in IDLE
- num  in  NUM_W  rolled value, unsigned, latched with pulse_i
- player  in  PW  rolling player index, latched with pulse_i
- choice  in  1  1 = keep, 0 = discard
- confirm  in  1  submit button, level
- result  out  2  00 CONTINUE, 01 LOST, 10 WON; valid with pulse_o, held until next pulse_o
- pulse_o  out  1  one-cycle turn-complete pulse
- timed_out  out  1  set with pulse_o when turn ended by timeout, held like result
- busy  out  1  state != IDLE
- scores  out  PLAYERS*SCORE_W  flat score vector, player p at [p*SCORE_W +: SCORE_W]

## Operation
- States: IDLE, CHECK, CHOOSE, HOLD. Registered state, timer, num/player latches, scores, result, pulse_o, timed_out.
- IDLE: pulse_i=1 latches num and player, -> CHECK. Other inputs are ignored.
- CHECK: if latched num == FORCE_NUM, apply KEEP, -> IDLE. Otherwise clear timer, -> CHOOSE.
- CHOOSE: confirm=1 -> HOLD. Otherwise, if TIMEOUT!=0 and timer == TIMEOUT-1, apply DISCARD with timed_out=1, -> IDLE. Otherwise timer++.
- HOLD: waits for release. When confirm=0, sample choice in that cycle: 1 applies KEEP, 0 applies DISCARD. Then -> IDLE. The timer does not run in HOLD.
- KEEP: sum = score[player] + num, computed in SCORE_W+NUM_W+1 bits, no truncation.
  - sum > TARGET: result LOST, score[player] <= 0.
  - sum == TARGET: result WON, score[player] <= TARGET.
  - otherwise: result CONTINUE, score[player] <= sum.
- DISCARD: result CONTINUE, score unchanged.
- Apply: pulse_o=1 for exactly the next cycle. result, timed_out and the score update become visible on the same edge. timed_out=0 for every non-timeout completion.
- Only the latched player's score changes; other scores are untouched.
- num=0 is legal; keeping it yields CONTINUE with an unchanged score.
- player >= PLAYERS: the turn completes with DISCARD semantics and no score write. Result is CONTINUE.

## Timing
- Reset (rst=1 at an edge): state IDLE, timer 0, all scores 0, result 00, pulse_o 0, timed_out 0, busy 0. Reset mid-turn drops the turn with no pulse_o.
- Priority: rst > clear_i > FSM. clear_i zeroes all scores and forces IDLE. It does not pulse; result and timed_out are unchanged.
- pulse_i sampled at edge t (IDLE) gives CHECK in cycle t+1.
  - Forced roll: pulse_o high in cycle t+2, busy low in t+2.
  - Non-forced roll: CHOOSE from t+2.
- Timeout: CHOOSE entered at cycle c with no confirm. pulse_o is high in cycle c+TIMEOUT.
- confirm seen high in CHOOSE at cycle k gives HOLD at k+1. First cycle r >= k+1 with confirm=0 in HOLD gives pulse_o high at r+1.
- confirm=1 on the same cycle as timeout expiry wins: -> HOLD, no timeout.
- pulse_i while busy, including the pulse_o cycle when state is already IDLE: accepted only when state is IDLE. pulse_i in the pulse_o cycle starts a new turn.

## Test plan
- PLAYERS=2, player 0 score 9, pulse_i with num=6 -> pulse_o at t+2, result WON, scores[0]=15, timed_out=0.
- Player 1 score 12, num=5, confirm held 3 cycles, choice=1 at release -> result LOST, scores[1]=0, scores[0] unchanged.
- Player 0 score 4, num=3, choice=0 -> CONTINUE, score 4. Repeat with choice=1 -> CONTINUE, score 7.
- TIMEOUT=8, num=2, no confirm -> pulse_o exactly 8 cycles after CHOOSE entry, timed_out=1, result CONTINUE, score unchanged. confirm on expiry cycle -> HOLD, no pulse.
- pulse_i asserted in CHOOSE with a different player/num -> ignored; the completed turn uses the originally latched values.
- rst in HOLD -> next cycle all scores 0, busy 0, pulse_o never asserted. clear_i in CHOOSE -> scores 0, IDLE, result keeps its prior value.
